// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and status encodings for the lock chamber controller
package lock_pkg;

  // Controller sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILLING  = 2'd1,
    DRAINING = 2'd2
  } state_t;

  // Bit positions inside water_status
  localparam int unsigned STAT_OK   = 1;
  localparam int unsigned STAT_HIGH = 0;

  // Whole-field encodings of water_status
  localparam logic [1:0] ST_MID  = 2'b00;
  localparam logic [1:0] ST_LOW  = 2'b10;
  localparam logic [1:0] ST_HIGH = 2'b11;

endpackage

// File: rtl/lock_chamber_ctrl_if.sv
// rtl/lock_chamber_ctrl_if.sv - request/status bundle between a lock operator and the chamber controller
interface lock_chamber_ctrl_if #(
  parameter int LEVEL_W = 6
);

  logic               fill_req;
  logic               drain_req;
  logic               abort;
  logic               gate_open;
  logic [LEVEL_W-1:0] water_level;
  logic [1:0]         water_status;
  logic               fill_valve;
  logic               drain_valve;
  logic               busy;
  logic               done;
  logic               req_err;

  // Operator side: issues requests, observes the chamber
  modport master (
    output fill_req, drain_req, abort, gate_open,
    input  water_level, water_status, fill_valve, drain_valve, busy, done, req_err
  );

  // Controller side
  modport slave (
    input  fill_req, drain_req, abort, gate_open,
    output water_level, water_status, fill_valve, drain_valve, busy, done, req_err
  );

endinterface

// File: rtl/lock_tick_gen.sv
// rtl/lock_tick_gen.sv - rate divider producing one level-step tick every TICK_DIV unfrozen cycles
module lock_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // A tick fires on the last count of a period unless motion is frozen
  assign tick = !hold && (cnt == LAST);

  // Counter restarts on clear, freezes on hold, wraps after the last count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lock_chamber_ctrl.sv
// rtl/lock_chamber_ctrl.sv - canal-lock chamber level register with rate-limited fill/drain sequencing
module lock_chamber_ctrl #(
  parameter int LEVEL_W     = 6,
  parameter int LOW_THRESH  = 3,
  parameter int HIGH_THRESH = 47,
  parameter int MAX_LEVEL   = 50,
  parameter int STEP        = 1,
  parameter int TICK_DIV    = 4,
  parameter int RESET_LEVEL = 0
) (
  input logic                clk,
  input logic                reset,
  lock_chamber_ctrl_if.slave bus
);

  import lock_pkg::*;

  // Threshold ordering guarantees every fill eventually crosses HIGH_THRESH
  if (!(LOW_THRESH <= HIGH_THRESH && HIGH_THRESH < MAX_LEVEL && MAX_LEVEL < 2**LEVEL_W &&
        STEP >= 1 && TICK_DIV >= 1 && RESET_LEVEL <= MAX_LEVEL && RESET_LEVEL >= 0)) begin : g_bad_params
    $error("lock_chamber_ctrl: inconsistent parameters");
  end

  // One extra bit so step arithmetic can never wrap
  localparam logic [LEVEL_W:0]   STEP_X  = (LEVEL_W+1)'(STEP);
  localparam logic [LEVEL_W:0]   MAX_X   = (LEVEL_W+1)'(MAX_LEVEL);
  localparam logic [LEVEL_W:0]   HIGH_X  = (LEVEL_W+1)'(HIGH_THRESH);
  localparam logic [LEVEL_W:0]   LOW_X   = (LEVEL_W+1)'(LOW_THRESH);
  localparam logic [LEVEL_W-1:0] RESET_L = LEVEL_W'(RESET_LEVEL);

  state_t             state;
  logic [LEVEL_W-1:0] level;
  logic [LEVEL_W:0]   sum;
  logic [LEVEL_W:0]   diff;
  logic [LEVEL_W-1:0] fill_next;
  logic [LEVEL_W-1:0] drain_next;
  logic               is_low;
  logic               is_high;
  logic               tick;
  logic               active;

  assign active = (state != IDLE);

  lock_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clear(!active),
    .hold (bus.gate_open),
    .tick (tick)
  );

  // Saturating next-level candidates for each direction
  assign sum        = {1'b0, level} + STEP_X;
  assign diff       = {1'b0, level} - STEP_X;
  assign fill_next  = (sum > MAX_X) ? MAX_X[LEVEL_W-1:0] : sum[LEVEL_W-1:0];
  assign drain_next = diff[LEVEL_W] ? '0 : diff[LEVEL_W-1:0];

  assign is_low  = ({1'b0, level} < LOW_X);
  assign is_high = ({1'b0, level} > HIGH_X);

  // Gate-permission status classified from the registered level
  always_comb begin
    bus.water_status = ST_MID;
    if (is_high) begin
      bus.water_status = ST_HIGH;
    end else if (is_low) begin
      bus.water_status = ST_LOW;
    end
  end

  assign bus.water_level = level;
  assign bus.busy        = active;
  assign bus.fill_valve  = (state == FILLING)  && !bus.gate_open;
  assign bus.drain_valve = (state == DRAINING) && !bus.gate_open;

  // Sequencer: accepts requests in IDLE, steps level on ticks, abort wins over a tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      level       <= RESET_L;
      bus.done    <= 1'b0;
      bus.req_err <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.req_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.fill_req && bus.drain_req) begin
            bus.req_err <= 1'b1;
          end else if (bus.fill_req) begin
            if (is_high) bus.done <= 1'b1;
            else         state    <= FILLING;
          end else if (bus.drain_req) begin
            if (is_low) bus.done <= 1'b1;
            else        state    <= DRAINING;
          end
        end
        FILLING: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (tick) begin
            level <= fill_next;
            if ({1'b0, fill_next} > HIGH_X) begin
              state    <= IDLE;
              bus.done <= 1'b1;
            end
          end
        end
        DRAINING: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (tick) begin
            level <= drain_next;
            if ({1'b0, drain_next} < LOW_X) begin
              state    <= IDLE;
              bus.done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
